// File: rtl/ahbl_sram_slave.sv
// ahbl_sram_slave
// ---------------
// AHB-lite responder backed by an internal word-addressed SRAM array.
// It terminates one slave port of the bus matrix. HADDR[31:24] is decoded
// upstream into HSEL, and this block looks only at HADDR[23:0].
//
// Build option:
//   AHBL_SRAM_ERR_EN  When defined, out-of-range, misaligned and oversized
//                     transfers get the two-cycle ERROR response and never
//                     touch the array. When undefined, there is no ERROR path
//                     and HRESP is always 0. Addresses alias into the array
//                     using HADDR[DEPTH_LOG2+1:2]. Misaligned halfword/word
//                     accesses use aligned lanes, and HSIZE>2 acts as a word.
//
// Parameters:
//   DEPTH_LOG2   log2 of the array depth in 32-bit words (2..22)
//   WAIT_STATES  wait cycles inserted in each OKAY data phase (0..15)
//
// Ports:
//   HCLK, HRESET        clock and synchronous active-high reset
//   HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY
//                       AHB-lite slave inputs
//   HREADYOUT, HRDATA, HRESP
//                       AHB-lite slave outputs
//   dbg_state           current FSM state (0 IDLE, 1 WAIT, 2 ERR1, 3 ERR2)
//
// Handshake: an address phase is taken at a rising edge when
// HSEL & HTRANS[1] & HREADY is true and the FSM can accept a transfer.
// A data phase completes at the rising edge where HREADYOUT is 1.
// Write data is sampled from HWDATA at that edge. Read data on HRDATA
// is valid while HREADYOUT is 1.
module ahbl_sram_slave #(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic [1:0]  dbg_state
);

  localparam int unsigned AW    = DEPTH_LOG2 + 2;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [2:0]      size_q, size_d;
  logic            write_q, write_d;
  logic            hreadyout_q, hreadyout_d;
  logic            hresp_q, hresp_d;

  logic [31:0]     mem [DEPTH];

  logic                  last_wait;
  logic                  can_accept;
  logic                  accept;
  logic                  req_err;
  logic                  commit;
  logic [3:0]            be;
  logic [DEPTH_LOG2-1:0] word_idx;

  // Classify the incoming address phase.
`ifdef AHBL_SRAM_ERR_EN
  always_comb begin
    req_err = 1'b0;
    // The shift covers DEPTH_LOG2=22, where no out-of-range bits remain.
    if ((HADDR[23:0] >> AW) != 24'd0)             req_err = 1'b1;
    if (HSIZE > 3'd2)                             req_err = 1'b1;
    if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00)) req_err = 1'b1;
    if ((HSIZE == 3'd1) && HADDR[0])              req_err = 1'b1;
  end
`else
  assign req_err = 1'b0;
`endif

  // Inputs that are intentionally ignored by this slave.
  logic unused_inputs;
  assign unused_inputs = ^{HADDR[31:AW], HTRANS[0]};

  assign last_wait  = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  // A new address phase overlaps the final cycle of a data phase.
  assign can_accept = (state_q == ST_IDLE) || last_wait || (state_q == ST_ERR2);
  assign accept     = can_accept && HSEL && HTRANS[1] && HREADY;
  assign commit     = last_wait && write_q;
  assign word_idx   = addr_q[AW-1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;

    case (state_q)
      ST_WAIT: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = ST_IDLE;
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      addr_d  = HADDR[AW-1:0];
      size_d  = HSIZE;
      write_d = HWRITE;
      if (req_err) begin
        state_d = ST_ERR1;
      end else begin
        state_d = ST_WAIT;
        cnt_d   = 4'(WAIT_STATES);
      end
    end

    // The outputs are registered from the next state, so they line up
    // with the state they describe.
    hreadyout_d = !(((state_d == ST_WAIT) && (cnt_d != 4'd0)) || (state_d == ST_ERR1));
    hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      size_q      <= 3'd0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      write_q     <= write_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  // Little-endian lane enables. Halfword lanes come from addr[1] only, so
  // a misaligned halfword in the aliasing build still hits aligned lanes.
  always_comb begin
    case (size_q)
      3'd0:    be = 4'b0001 << addr_q[1:0];
      3'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // The array is not reset. A write pending when HRESET arrives is dropped.
  always_ff @(posedge HCLK) begin
    if (!HRESET && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  // A write that commits on the edge that accepts a read is already in the
  // array when that read's data phase starts, so no forwarding is needed.
  assign HRDATA    = ((state_q == ST_WAIT) && !write_q) ? mem[word_idx] : 32'd0;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Directed bench for ahbl_sram_slave. u_ws0 is a zero-wait instance and
// u_ws3 has three wait states. Only one of them is selected at a time, and
// the bench plays the bus, feeding the selected HREADYOUT back as HREADY.
module tb_ahbl_sram_slave;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // bus drive
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        use3;
  logic        hold_low;

  logic        ro0, rs0, ro3, rs3;
  logic [31:0] rd0, rd3;
  logic [1:0]  st0, st3;
  logic        hready;
  logic        ro, rs;
  logic [31:0] rd;
  logic [1:0]  st;

  assign ro     = use3 ? ro3 : ro0;
  assign rs     = use3 ? rs3 : rs0;
  assign rd     = use3 ? rd3 : rd0;
  assign st     = use3 ? st3 : st0;
  assign hready = hold_low ? 1'b0 : ro;

  ahbl_sram_slave #(.DEPTH_LOG2(8), .WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel & ~use3), .HADDR(haddr),
    .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata),
    .HREADY(hready), .HREADYOUT(ro0), .HRDATA(rd0), .HRESP(rs0),
    .dbg_state(st0)
  );

  ahbl_sram_slave #(.DEPTH_LOG2(8), .WAIT_STATES(3)) u_ws3 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel & use3), .HADDR(haddr),
    .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata),
    .HREADY(hready), .HREADYOUT(ro3), .HRDATA(rd3), .HRESP(rs3),
    .dbg_state(st3)
  );

  // scoreboard
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  logic [31:0] rdata, rd_first;
  logic        resp_low, resp_fin;
  int          lows;

  // Single non-pipelined transfer. Call at #1 after a posedge with the
  // selected slave idle; returns at #1 after a posedge with it idle again.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata);
    bit done;
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr; hsize = size;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = wdata;
    lows = 0; resp_low = 1'b0; resp_fin = 1'b0; rdata = '0; done = 1'b0;
    rd_first = rd;
    for (int i = 0; i < 20; i++) begin
      if (ro) begin
        rdata = rd; resp_fin = rs; done = 1'b1;
        break;
      end
      lows++; resp_low = rs;
      @(posedge clk); #1;
    end
    if (!done) check("xfer_timeout", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    xfer(1'b0, addr, 3'd2, 32'd0);
    check(tag, rdata, exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hsize = 3'd0;
    hwrite = 1'b0; hwdata = '0; use3 = 1'b0; hold_low = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy0", 32'(ro0), 32'd1);
    check("rst_resp0", 32'(rs0), 32'd0);
    check("rst_rdata0", rd0, 32'd0);
    check("rst_rdy3", 32'(ro3), 32'd1);
    check("rst_state3", 32'(st3), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero-wait write followed back-to-back by a read of the same word.
    use3 = 1'b0;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2;
    @(posedge clk); #1;
    check("b2b_w_rdy", 32'(ro), 32'd1);
    hwdata = 32'hDEADBEEF; hwrite = 1'b0;
    @(posedge clk); #1;
    check("b2b_r_rdy", 32'(ro), 32'd1);
    check("b2b_rdata", rd, 32'hDEADBEEF);
    check("b2b_resp", 32'(rs), 32'd0);
    hsel = 1'b0; htrans = 2'b00;
    @(posedge clk); #1;
    check("b2b_idle_rdata", rd, 32'd0);

    // Three wait states on a write and then on a read.
    use3 = 1'b1;
    xfer(1'b1, 32'h0, 3'd2, 32'h12345678);
    check("ws3_w_lows", 32'(lows), 32'd3);
    xfer(1'b0, 32'h0, 3'd2, 32'd0);
    check("ws3_r_lows", 32'(lows), 32'd3);
    check("ws3_r_first", rd_first, 32'h12345678);
    check("ws3_r_data", rdata, 32'h12345678);
    check("ws3_r_resp", 32'(resp_fin), 32'd0);

    // Byte and halfword lane writes.
    use3 = 1'b0;
    xfer(1'b1, 32'h4, 3'd2, 32'h11223344);
    xfer(1'b1, 32'h5, 3'd0, 32'hAAAAAAAA);
    read_chk("lane_byte", 32'h4, 32'h1122AA44);
    xfer(1'b1, 32'h6, 3'd1, 32'hBEEFBEEF);
    read_chk("lane_half", 32'h4, 32'hBEEFAA44);
    xfer(1'b1, 32'h8, 3'd2, 32'h00000000);
    xfer(1'b1, 32'h8, 3'd1, 32'h5566CAFE);
    read_chk("lane_half_lo", 32'h8, 32'h0000CAFE);

`ifdef AHBL_SRAM_ERR_EN
    xfer(1'b1, 32'h0, 3'd2, 32'hCAFEF00D);
    xfer(1'b1, 32'h402, 3'd2, 32'hFFFFFFFF);
    check("err_range_lows", 32'(lows), 32'd1);
    check("err_range_resp1", 32'(resp_low), 32'd1);
    check("err_range_resp2", 32'(resp_fin), 32'd1);
    read_chk("err_range_keep", 32'h0, 32'hCAFEF00D);
    xfer(1'b1, 32'h403, 3'd2, 32'hFFFFFFFF);
    check("err_mis_lows", 32'(lows), 32'd1);
    check("err_mis_resp", 32'(resp_fin), 32'd1);
    xfer(1'b1, 32'h1, 3'd1, 32'hFFFFFFFF);
    check("err_half_resp", 32'(resp_low), 32'd1);
    xfer(1'b0, 32'h0, 3'd3, 32'd0);
    check("err_size_resp", 32'(resp_fin), 32'd1);
    check("err_size_rdata", rdata, 32'd0);
    read_chk("err_mis_keep", 32'h0, 32'hCAFEF00D);
`else
    xfer(1'b1, 32'h400, 3'd2, 32'h5A5A1234);
    check("alias_lows", 32'(lows), 32'd0);
    check("alias_resp", 32'(resp_fin), 32'd0);
    read_chk("alias_data", 32'h0, 32'h5A5A1234);
`endif

    // Address phase held while HREADY is low: accepted only once HREADY rises.
    use3 = 1'b1;
    hold_low = 1'b1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h20; hsize = 3'd2;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("hold_no_accept", 32'(st), 32'd0);
    end
    hold_low = 1'b0;
    @(posedge clk); #1;
    check("hold_accept", 32'(st), 32'd1);
    check("hold_rdy_low", 32'(ro), 32'd0);
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h0BADCAFE;
    lows = 1;
    for (int i = 0; i < 20 && !ro; i++) begin
      @(posedge clk); #1;
      if (!ro) lows++;
    end
    check("hold_lows", 32'(lows), 32'd3);
    @(posedge clk); #1;
    check("hold_one_xfer", 32'(st), 32'd0);
    read_chk("hold_data", 32'h20, 32'h0BADCAFE);

    // Reset during the second wait cycle of a write.
    xfer(1'b1, 32'h30, 3'd2, 32'h01010101);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h30; hsize = 3'd2;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_rdy", 32'(ro), 32'd1);
    check("rstmid_resp", 32'(rs), 32'd0);
    check("rstmid_rdata", rd, 32'd0);
    check("rstmid_state", 32'(st), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    read_chk("rstmid_keep", 32'h30, 32'h01010101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
